// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and constants for the memory bus arbiter.
// Port ids, FSM state encoding and RAM size codes.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic PORT_C = 1'b0;
   localparam logic PORT_D = 1'b1;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;
   localparam logic [1:0] SIZE_D = 2'b11;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick.
// On a tie the port that did not win last time is chosen.
module rr_arbiter2
   import mem_bus_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       gnt_valid,
   output logic       gnt_port
);

   // req[1] is the DMA port, req[0] the CPU port
   always_comb begin
      gnt_valid = |req;
      gnt_port  = PORT_C;
      unique case (req)
         2'b11:   gnt_port = ~last_grant;
         2'b10:   gnt_port = PORT_D;
         default: gnt_port = PORT_C;
      endcase
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between CPU (C) and DMA (D).
// Round-robin grant, fixed-latency access, bounded locked DMA bursts.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 64,
   parameter int MEM_LAT   = 2,
   parameter int MAX_BURST = 4
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [1:0]        c_size,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_ack,
   output logic [DATA_W-1:0] c_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [1:0]        d_size,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic              d_lock,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        mem_size,
   output logic              mem_en,
   output logic              mem_write_en,
   output logic              mem_read,
   output logic              busy
);

   localparam logic [2:0] LAT_LAST   = 3'(MEM_LAT - 1);
   localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

   state_t            state_q, state_d;
   logic [2:0]        lat_q, lat_d;
   logic [3:0]        burst_q, burst_d;
   logic              last_q, last_d;
   logic              grant_q, grant_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] c_rd_q, c_rd_d;
   logic [DATA_W-1:0] d_rd_q, d_rd_d;

   logic arb_valid;
   logic arb_port;
   logic ld_en;
   logic ld_port;
   logic in_acc;
   logic in_done;
   logic burst_go;

   rr_arbiter2 u_arb (
      .req        ({d_req, c_req}),
      .last_grant (last_q),
      .gnt_valid  (arb_valid),
      .gnt_port   (arb_port)
   );

   // DMA keeps the port only while locked and under the burst limit
   assign burst_go = (grant_q == PORT_D) && d_req && d_lock &&
                     (burst_q < BURST_LAST);

   // state, counters, request latch and read-data registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         lat_q   <= '0;
         burst_q <= '0;
         last_q  <= PORT_D;
         grant_q <= PORT_C;
         we_q    <= 1'b0;
         size_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         c_rd_q  <= '0;
         d_rd_q  <= '0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         burst_q <= burst_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         we_q    <= we_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         c_rd_q  <= c_rd_d;
         d_rd_q  <= d_rd_d;
      end
   end

   // next-state: grant, count latency, complete, optionally chain a burst
   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      burst_d = burst_q;
      last_d  = last_q;
      grant_d = grant_q;
      we_d    = we_q;
      size_d  = size_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      c_rd_d  = c_rd_q;
      d_rd_d  = d_rd_q;
      ld_en   = 1'b0;
      ld_port = PORT_C;

      unique case (state_q)
         IDLE: begin
            if (arb_valid) begin
               ld_en   = 1'b1;
               ld_port = arb_port;
            end
         end
         ACCESS: begin
            if (lat_q == LAT_LAST) begin
               if (!we_q) begin
                  if (grant_q == PORT_D) d_rd_d = mem_rdata;
                  else                   c_rd_d = mem_rdata;
               end
               state_d = DONE;
            end else begin
               lat_d = lat_q + 3'd1;
            end
         end
         DONE: begin
            last_d = grant_q;
            if (burst_go) begin
               burst_d = burst_q + 4'd1;
               ld_en   = 1'b1;
               ld_port = PORT_D;
            end else begin
               burst_d = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (ld_en) begin
         grant_d = ld_port;
         we_d    = (ld_port == PORT_D) ? d_we    : c_we;
         size_d  = (ld_port == PORT_D) ? d_size  : c_size;
         addr_d  = (ld_port == PORT_D) ? d_addr  : c_addr;
         wdata_d = (ld_port == PORT_D) ? d_wdata : c_wdata;
         lat_d   = '0;
         state_d = ACCESS;
      end
   end

   // strobes follow the state register so reset clears them at once
   assign in_acc  = (state_q == ACCESS);
   assign in_done = (state_q == DONE);

   assign mem_en       = in_acc;
   assign mem_write_en = in_acc & we_q;
   assign mem_read     = in_acc & ~we_q;
   assign mem_address  = in_acc ? addr_q  : '0;
   assign mem_wdata    = in_acc ? wdata_q : '0;
   assign mem_size     = in_acc ? size_q  : '0;

   assign c_ack   = in_done & (grant_q == PORT_C);
   assign d_ack   = in_done & (grant_q == PORT_D);
   assign c_rdata = c_rd_q;
   assign d_rdata = d_rd_q;
   assign busy    = (state_q != IDLE);

endmodule
